uart_byte_rx: RTL

//  UART receiver for the uart_byte_tx link: 8N1 (optional parity), LSB first, idle-high line.
//  16x oversampling, 5-sample majority vote per bit, false-start rejection, stop-bit check.

---
 rtl/uart_byte_rx_if.sv | 17 +
 rtl/uart_byte_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: received-byte bus between uart_byte_rx and the byte consumer.
//   data_byte   last correctly received byte
//   Rx_Done     1-cycle pulse, data_byte updated with a good frame
//   Frame_Err   1-cycle pulse, stop bit sampled low
//   Parity_Err  1-cycle pulse, parity mismatch (0 unless UART_RX_PARITY_EN)
//   uart_state  high while a frame is being received
// master = receiver side (drives), slave = consumer side.
interface uart_byte_rx_if;
  logic [7:0] data_byte;
  logic       Rx_Done;
  logic       Frame_Err;
  logic       Parity_Err;
  logic       uart_state;

  modport master (output data_byte, Rx_Done, Frame_Err, Parity_Err, uart_state);
  modport slave  (input  data_byte, Rx_Done, Frame_Err, Parity_Err, uart_state);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver (optional parity), LSB first, idle-high line.
// 16x oversampling, 5-sample majority vote (samples 6..10), false-start
// rejection and stop-bit check. Baud table matches uart_byte_tx at 50 MHz.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data).
// Ports:
//   Clk       system clock, 50 MHz nominal
//   Rst_n     asynchronous active-low reset
//   baud_set  0:9600 1:19200 2:38400 3:57600 4:115200 5-7:9600
//   Rs232_Rx  serial input, asynchronous to Clk
//   bus       uart_byte_rx_if.master: data_byte, Rx_Done, Frame_Err,
//             Parity_Err, uart_state
// Parameters: SYNC_STAGES (2..4) synchroniser depth, PARITY_ODD (0 even, 1 odd).
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | validating the start bit, back to IDLE if it votes high
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, report result at sample 10
module uart_byte_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [2:0]            baud_set,
  input  logic                  Rs232_Rx,
  uart_byte_rx_if.master        bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_byte_rx: illegal SYNC_STAGES or PARITY_ODD");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic logic [15:0] div_for(input logic [2:0] b);
    case (b)
      3'd1:    div_for = 16'd162;
      3'd2:    div_for = 16'd80;
      3'd3:    div_for = 16'd53;
      3'd4:    div_for = 16'd26;
      default: div_for = 16'd324;
    endcase
  endfunction

  state_t           state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rx_s;
  logic             rx_prev;
  logic [2:0]       baud_q;
  logic [15:0]      div_cnt;
  logic [15:0]      div_val;
  logic [3:0]       samp_cnt;
  logic [2:0]       bit_cnt;
  logic [2:0]       ones_cnt;
  logic [2:0]       vote_sum;
  logic [7:0]       rx_shift;
  logic [7:0]       data_q;
  logic             done_q;
  logic             ferr_q;
  logic             busy_q;
  logic             tick;
  logic             vote;
  logic             in_window;
  logic             start_det;
`ifdef UART_RX_PARITY_EN
  logic             parity_q;
  logic             perr_q;
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a phantom start.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], Rs232_Rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    div_val   = div_for(baud_q);
    tick      = (state != IDLE) && (div_cnt == div_val);
    vote_sum  = ones_cnt + {2'b00, rx_s};
    vote      = (vote_sum >= 3'd3);
    in_window = (samp_cnt >= 4'd6) && (samp_cnt <= 4'd10);
    start_det = rx_prev & ~rx_s;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      rx_prev  <= 1'b1;
      baud_q   <= 3'd0;
      div_cnt  <= 16'd0;
      samp_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      ones_cnt <= 3'd0;
      rx_shift <= 8'd0;
      data_q   <= 8'd0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      rx_prev <= rx_s;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif

      if (state == IDLE || tick) div_cnt <= 16'd0;
      else                       div_cnt <= div_cnt + 16'd1;

      // Vote accumulator restarts at sample 6 of every bit.
      if (tick) begin
        samp_cnt <= samp_cnt + 4'd1;
        if (in_window)
          ones_cnt <= (samp_cnt == 4'd6) ? {2'b00, rx_s} : vote_sum;
      end

      case (state)
        IDLE: begin
          if (start_det) begin
            state    <= START;
            busy_q   <= 1'b1;
            baud_q   <= baud_set;
            samp_cnt <= 4'd0;
          end
        end
        START: begin
          if (tick && samp_cnt == 4'd10 && vote) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (tick && samp_cnt == 4'd15) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          if (tick && samp_cnt == 4'd10) rx_shift <= {vote, rx_shift[7:1]};
          if (tick && samp_cnt == 4'd15) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick && samp_cnt == 4'd10) parity_q <= vote;
          if (tick && samp_cnt == 4'd15) state <= STOP;
        end
`endif
        STOP: begin
          // Leave at sample 10 so a back-to-back start edge is not missed.
          if (tick && samp_cnt == 4'd10) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (!vote) begin
              ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parity_q != (^rx_shift ^ 1'(PARITY_ODD))) begin
              perr_q <= 1'b1;
`endif
            end else begin
              data_q <= rx_shift;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_byte  = data_q;
  assign bus.Rx_Done    = done_q;
  assign bus.Frame_Err  = ferr_q;
  assign bus.uart_state = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.Parity_Err = perr_q;
`else
  assign bus.Parity_Err = 1'b0;
`endif

endmodule
